iob_nbus_ram_responder: RTL and testbench

Subordinate (responder) end of the IOb native bus: a single-port, byte-writable RAM that answers CPU instruction or data bus requests. It accepts one request per `avalid`/`ready` handshake, applies byte-strobed writes immediately, and returns read data after a configurable latency. While a multi-cycle read is in flight it holds `ready` low. It sits behind the CPU wrapper's `ibus`/`dbus` ports, and behind the interconnect split, as boot/scratch memory and as the reference responder for bus verification.

---
 rtl/iob_nbus_ram_responder.sv | 118 +++++++++++
 tb/tb_iob_nbus_ram_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_nbus_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : iob_nbus_ram_responder
// Brief    : IOb native-bus responder backed by a byte-writable single-port RAM
//            with configurable read latency (1..4 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module iob_nbus_ram_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int READ_LAT   = 1
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_i,
    input  logic                iob_avalid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_ready_o,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o
);

    localparam int         STRB_W    = DATA_W / 8;
    localparam int         MEM_DEPTH = 2 ** MEM_ADDR_W;
    localparam logic [2:0] LAT_LOAD  = 3'(READ_LAT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            lat_cnt_q, lat_cnt_d;
    logic [MEM_ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;

    logic [DATA_W-1:0]     mem [MEM_DEPTH];

    logic [MEM_ADDR_W-1:0] req_idx;
    logic                  is_write;
    logic                  accept;
    logic                  addr_unused;

    assign req_idx     = iob_addr_i[MEM_ADDR_W+1:2];
    assign addr_unused = ^{iob_addr_i[ADDR_W-1:MEM_ADDR_W+2], iob_addr_i[1:0]};
    assign is_write    = |iob_wstrb_i;
    assign accept      = iob_avalid_i & (state_q == ST_IDLE) & cke_i;

    // Memory cannot change while a read waits (ready is low), so the stored
    // word index is enough to fetch the sampled word at delivery time.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        rd_idx_d  = rd_idx_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !is_write) begin
                    if (READ_LAT == 1) begin
                        rvalid_d = 1'b1;
                        rdata_d  = mem[req_idx];
                    end else begin
                        state_d   = ST_WAIT;
                        lat_cnt_d = LAT_LOAD;
                        rd_idx_d  = req_idx;
                    end
                end
            end
            ST_WAIT: begin
                lat_cnt_d = lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) begin
                    state_d  = ST_IDLE;
                    rvalid_d = 1'b1;
                    rdata_d  = mem[rd_idx_q];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= 3'd0;
            rd_idx_q  <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else if (cke_i) begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            rd_idx_q  <= rd_idx_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive arst_i.
    always_ff @(posedge clk_i) begin
        if (accept && is_write) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (iob_wstrb_i[k]) begin
                    mem[req_idx][k*8 +: 8] <= iob_wdata_i[k*8 +: 8];
                end
            end
        end
    end

    assign iob_ready_o  = (state_q == ST_IDLE);
    assign iob_rvalid_o = rvalid_q;
    assign iob_rdata_o  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_iob_nbus_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_nbus_ram_responder
// Brief    : Four responders (READ_LAT 1..4) driven by directed sequences and
//            checked every cycle against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_nbus_ram_responder;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        cke    [NI];
    logic        arst   [NI];
    logic        avalid [NI];
    logic [31:0] addr   [NI];
    logic [31:0] wdata  [NI];
    logic [3:0]  wstrb  [NI];
    logic        ready  [NI];
    logic        rvalid [NI];
    logic [31:0] rdata  [NI];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int inst, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s (lat%0d): got %h expected %h", nm, inst + 1, got, want);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int LAT = gi + 1;

        iob_nbus_ram_responder #(
            .ADDR_W    (32),
            .DATA_W    (32),
            .MEM_ADDR_W(10),
            .READ_LAT  (LAT)
        ) u_dut (
            .clk_i       (clk),
            .cke_i       (cke[gi]),
            .arst_i      (arst[gi]),
            .iob_avalid_i(avalid[gi]),
            .iob_addr_i  (addr[gi]),
            .iob_wdata_i (wdata[gi]),
            .iob_wstrb_i (wstrb[gi]),
            .iob_ready_o (ready[gi]),
            .iob_rvalid_o(rvalid[gi]),
            .iob_rdata_o (rdata[gi])
        );

        // Reference: word map, plus at most one outstanding read stamped with
        // the enabled-edge count at which it must be delivered.
        logic [31:0] mmem [int];
        bit          pend;
        longint      ecnt, due;
        logic [31:0] pdata;
        logic        m_ready, m_rvalid;
        logic [31:0] m_rdata;

        initial begin
            pend = 0; ecnt = 0; due = 0; pdata = 0;
            m_ready = 1'b1; m_rvalid = 1'b0; m_rdata = 32'h0;
        end

        always @(negedge clk) begin : p_cmp
            int          idx;
            logic [31:0] w;
            if (arst[gi]) begin
                pend = 0; m_ready = 1'b1; m_rvalid = 1'b0; m_rdata = 32'h0;
            end
            chk("model_ready",  gi, {31'd0, ready[gi]},  {31'd0, m_ready});
            chk("model_rvalid", gi, {31'd0, rvalid[gi]}, {31'd0, m_rvalid});
            chk("model_rdata",  gi, rdata[gi], m_rdata);
            if (!arst[gi] && cke[gi]) begin
                idx = int'(addr[gi][11:2]);
                if (avalid[gi] && m_ready) begin
                    if (wstrb[gi] != 4'h0) begin
                        w = mmem.exists(idx) ? mmem[idx] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (wstrb[gi][b]) w[b*8 +: 8] = wdata[gi][b*8 +: 8];
                        mmem[idx] = w;
                    end else begin
                        pend  = 1;
                        due   = ecnt + LAT;
                        pdata = mmem.exists(idx) ? mmem[idx] : 32'h0;
                    end
                end
                ecnt++;
                m_rvalid = 1'b0;
                if (pend && ecnt == due) begin
                    pend     = 0;
                    m_rvalid = 1'b1;
                    m_rdata  = pdata;
                end
                m_ready = !pend;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int k, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        avalid[k] = 1'b1; addr[k] = a; wdata[k] = d; wstrb[k] = s;
    endtask

    task automatic idle(input int k);
        avalid[k] = 1'b0; wstrb[k] = 4'h0;
    endtask

    task automatic wr1(input int k, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        req(k, a, d, s);
        tick();
        idle(k);
    endtask

    task automatic chk_out(input int k, input string nm, input logic rdy,
                           input logic rv, input logic [31:0] rd);
        chk({nm, "_ready"},  k, {31'd0, ready[k]},  {31'd0, rdy});
        chk({nm, "_rvalid"}, k, {31'd0, rvalid[k]}, {31'd0, rv});
        chk({nm, "_rdata"},  k, rdata[k], rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            cke[k] = 1'b1; arst[k] = 1'b1; avalid[k] = 1'b0;
            addr[k] = 32'h0; wdata[k] = 32'h0; wstrb[k] = 4'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) arst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) chk_out(k, "reset", 1'b1, 1'b0, 32'h0);
        tick();

        // ---------------- READ_LAT = 1 ----------------
        req(0, 32'h10, 32'hDEADBEEF, 4'hF); tick();
        req(0, 32'h10, 32'h0, 4'h0);        tick(); idle(0);
        @(negedge clk); chk_out(0, "raw", 1'b1, 1'b1, 32'hDEADBEEF);
        tick();
        wr1(0, 32'h20, 32'h11223344, 4'hF);
        wr1(0, 32'h20, 32'hAABBCCDD, 4'h5);
        req(0, 32'h20, 32'h0, 4'h0); tick(); idle(0);
        @(negedge clk); chk_out(0, "strobe", 1'b1, 1'b1, 32'h11BB33DD);
        tick();
        wr1(0, 32'h30, 32'h12345678, 4'hF);
        @(negedge clk); chk_out(0, "hold_after_wr", 1'b1, 1'b0, 32'h11BB33DD);
        tick();
        req(0, 32'h10, 32'h0, 4'h0); tick();
        req(0, 32'h20, 32'h0, 4'h0);
        @(negedge clk); chk_out(0, "b2b_1", 1'b1, 1'b1, 32'hDEADBEEF);
        tick(); req(0, 32'h10, 32'h0, 4'h0);
        @(negedge clk); chk_out(0, "b2b_2", 1'b1, 1'b1, 32'h11BB33DD);
        tick(); req(0, 32'h1010, 32'h0, 4'h0);
        @(negedge clk); chk_out(0, "b2b_3", 1'b1, 1'b1, 32'hDEADBEEF);
        tick(); idle(0);
        @(negedge clk); chk_out(0, "alias", 1'b1, 1'b1, 32'hDEADBEEF);
        tick();
        @(negedge clk); chk_out(0, "b2b_end", 1'b1, 1'b0, 32'hDEADBEEF);
        tick();

        // ---------------- READ_LAT = 3 ----------------
        wr1(2, 32'h10, 32'hDEADBEEF, 4'hF);
        wr1(2, 32'h20, 32'h11223344, 4'hF);
        wr1(2, 32'h20, 32'hAABBCCDD, 4'h5);
        req(2, 32'h20, 32'h0, 4'h0); tick();
        req(2, 32'h10, 32'h0, 4'h0);
        @(negedge clk); chk_out(2, "lat3_t1", 1'b0, 1'b0, 32'h0);
        tick();
        @(negedge clk); chk_out(2, "lat3_t2", 1'b0, 1'b0, 32'h0);
        tick();
        @(negedge clk); chk_out(2, "lat3_t3", 1'b1, 1'b1, 32'h11BB33DD);
        tick(); idle(2);
        @(negedge clk); chk_out(2, "lat3_held_busy", 1'b0, 1'b0, 32'h11BB33DD);
        tick(); tick();
        @(negedge clk); chk_out(2, "lat3_held_done", 1'b1, 1'b1, 32'hDEADBEEF);
        tick();

        // ---------------- READ_LAT = 2, clock enable ----------------
        wr1(1, 32'h10, 32'hDEADBEEF, 4'hF);
        wr1(1, 32'h30, 32'h0BADF00D, 4'hF);
        req(1, 32'h10, 32'h0, 4'h0); tick(); idle(1); tick();
        @(negedge clk); chk_out(1, "lat2_nominal", 1'b1, 1'b1, 32'hDEADBEEF);
        tick();
        req(1, 32'h30, 32'h0, 4'h0); tick(); idle(1); cke[1] = 1'b0;
        @(negedge clk); chk_out(1, "cke_frz1", 1'b0, 1'b0, 32'hDEADBEEF);
        tick();
        @(negedge clk); chk_out(1, "cke_frz2", 1'b0, 1'b0, 32'hDEADBEEF);
        tick(); cke[1] = 1'b1;
        @(negedge clk); chk_out(1, "cke_resume", 1'b0, 1'b0, 32'hDEADBEEF);
        tick(); cke[1] = 1'b0;
        @(negedge clk); chk_out(1, "cke_late_rv", 1'b1, 1'b1, 32'h0BADF00D);
        tick(); cke[1] = 1'b1;
        @(negedge clk); chk_out(1, "cke_stretch", 1'b1, 1'b1, 32'h0BADF00D);
        tick();
        @(negedge clk); chk_out(1, "cke_stretch_end", 1'b1, 1'b0, 32'h0BADF00D);
        tick();

        // ---------------- READ_LAT = 4, reset mid-read ----------------
        wr1(3, 32'h10, 32'hDEADBEEF, 4'hF);
        req(3, 32'h10, 32'h0, 4'h0); tick(); idle(3);
        repeat (3) tick();
        @(negedge clk); chk_out(3, "lat4_nominal", 1'b1, 1'b1, 32'hDEADBEEF);
        tick();
        req(3, 32'h10, 32'h0, 4'h0); tick(); idle(3);
        arst[3] = 1'b1;
        #1;
        chk_out(3, "arst_immediate", 1'b1, 1'b0, 32'h0);
        tick(); arst[3] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); chk(("arst_no_rvalid"), 3, {31'd0, rvalid[3]}, 32'h0);
            tick();
        end
        req(3, 32'h10, 32'h0, 4'h0); tick(); idle(3);
        repeat (3) tick();
        @(negedge clk); chk_out(3, "arst_mem_kept", 1'b1, 1'b1, 32'hDEADBEEF);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
